// File: rtl/sfx_sequencer.sv
// Multi-channel sound-effect engine: per-channel note sequencers producing square waves,
// mixed with panning and saturation into registered signed 16-bit left/right samples.

module sfx_channel #(
  parameter int          STEPS       = 8,
  parameter int          NOTE_W      = 22,
  parameter int          STEP_CYCLES = 12_500_000,
  parameter logic [15:0] AMP         = 16'h1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger_i,
  input  logic                    stop_i,
  input  logic                    loop_en_i,
  input  logic [STEPS*NOTE_W-1:0] notes_i,
  output logic [15:0]             level_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int TON_W = NOTE_W - 1;
  localparam logic [0:0]        S_IDLE   = 1'b0;
  localparam logic [0:0]        S_PLAY   = 1'b1;
  localparam logic [NOTE_W-1:0] NOTE_END = {NOTE_W{1'b1}};
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(STEPS - 1);
  localparam logic [TMR_W-1:0]  LAST_TMR = TMR_W'(STEP_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic             trig_q;
  logic [IDX_W-1:0] step_q, step_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TON_W-1:0] tone_q, tone_d;
  logic             phase_q, phase_d;
  logic             done_q, done_d;

  logic [STEPS-1:0][NOTE_W-1:0] notes;
  logic [NOTE_W-1:0] cur_note;
  logic [TON_W-1:0]  half;
  logic [IDX_W-1:0]  nxt_idx;
  logic              is_tone, trig_edge, seq_end, restart;

  assign notes     = notes_i;
  assign cur_note  = notes[step_q];
  assign half      = cur_note[NOTE_W-1:1];
  assign is_tone   = (half != '0) && (cur_note != NOTE_END);
  assign trig_edge = trigger_i & ~trig_q;
  assign nxt_idx   = step_q + IDX_W'(1);
  assign seq_end   = (step_q == LAST_IDX) || (notes[nxt_idx] == NOTE_END);

  // Priority: stop, then trigger edge, then step timing.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    timer_d = timer_q;
    tone_d  = tone_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    restart = 1'b0;
    if (stop_i) begin
      state_d = S_IDLE;
    end else if (trig_edge) begin
      if (notes[0] == NOTE_END) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = S_PLAY;
        restart = 1'b1;
      end
    end else if (state_q == S_PLAY) begin
      if (timer_q == LAST_TMR) begin
        if (seq_end) begin
          done_d = 1'b1;
          if (loop_en_i) restart = 1'b1;
          else           state_d = S_IDLE;
        end else begin
          step_d  = nxt_idx;
          timer_d = '0;
          tone_d  = '0;
          phase_d = 1'b1;
        end
      end else begin
        timer_d = timer_q + TMR_W'(1);
        if (is_tone) begin
          // >= keeps the counter bounded if the note shrinks mid-step
          if (tone_q >= half - TON_W'(1)) begin
            tone_d  = '0;
            phase_d = ~phase_q;
          end else begin
            tone_d = tone_q + TON_W'(1);
          end
        end
      end
    end
    if (restart) begin
      step_d  = '0;
      timer_d = '0;
      tone_d  = '0;
      phase_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      step_q  <= '0;
      timer_q <= '0;
      tone_q  <= '0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trigger_i;
      step_q  <= step_d;
      timer_q <= timer_d;
      tone_q  <= tone_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  assign level_o = (state_q == S_PLAY && is_tone) ? (phase_q ? AMP : 16'(-AMP)) : 16'h0000;
  assign busy_o  = (state_q == S_PLAY);
  assign done_o  = done_q;
endmodule

module sfx_sequencer #(
  parameter int          CHANNELS    = 2,
  parameter int          STEPS       = 8,
  parameter int          NOTE_W      = 22,
  parameter int          STEP_CYCLES = 12_500_000,
  parameter logic [15:0] AMP         = 16'h1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS-1:0]              trigger,
  input  logic [CHANNELS-1:0]              stop,
  input  logic [CHANNELS-1:0]              loop_en,
  input  logic [CHANNELS-1:0]              pan_left,
  input  logic [CHANNELS-1:0]              pan_right,
  input  logic [CHANNELS*STEPS*NOTE_W-1:0] seq_notes,
  output logic [15:0]                      audio_left,
  output logic [15:0]                      audio_right,
  output logic [CHANNELS-1:0]              busy,
  output logic [CHANNELS-1:0]              done
);
  localparam int SUM_W = 17 + $clog2(CHANNELS);

  logic [CHANNELS-1:0][15:0] lvl;
  logic [SUM_W-1:0]          sum_l, sum_r;
  logic [15:0]               audio_left_q, audio_right_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sfx_channel #(
      .STEPS(STEPS), .NOTE_W(NOTE_W), .STEP_CYCLES(STEP_CYCLES), .AMP(AMP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .trigger_i (trigger[c]),
      .stop_i    (stop[c]),
      .loop_en_i (loop_en[c]),
      .notes_i   (seq_notes[c*STEPS*NOTE_W +: STEPS*NOTE_W]),
      .level_o   (lvl[c]),
      .busy_o    (busy[c]),
      .done_o    (done[c])
    );
  end

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (pan_left[c])  sum_l = sum_l + {{(SUM_W-16){lvl[c][15]}}, lvl[c]};
      if (pan_right[c]) sum_r = sum_r + {{(SUM_W-16){lvl[c][15]}}, lvl[c]};
    end
  end

  // In range iff all bits above bit 14 agree with the sign.
  function automatic logic [15:0] sat16(input logic [SUM_W-1:0] s);
    if ((&s[SUM_W-1:15]) || !(|s[SUM_W-1:15])) return s[15:0];
    return s[SUM_W-1] ? 16'h8000 : 16'h7FFF;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_left_q  <= 16'h0000;
      audio_right_q <= 16'h0000;
    end else begin
      audio_left_q  <= sat16(sum_l);
      audio_right_q <= sat16(sum_r);
    end
  end

  assign audio_left  = audio_left_q;
  assign audio_right = audio_right_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// Randomised and directed bench for sfx_sequencer; an elapsed-time reference model predicts
// busy/done/audio for two instances (normal and saturating amplitude) every cycle.

module tb_sfx_sequencer;
  localparam int CH = 2, ST = 4, NW = 22, SC = 16;
  localparam logic [NW-1:0] ENDN = {NW{1'b1}};

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0] trigger, stop, loop_en, pan_left, pan_right;
  logic [CH*ST*NW-1:0] seq_notes;
  logic [15:0] al, ar, sl, sr;
  logic [CH-1:0] busy, done, sbusy, sdone;

  logic [NW-1:0] notes [CH][ST];

  always #5 clk = ~clk;

  always_comb begin
    seq_notes = '0;
    for (int c = 0; c < CH; c++)
      for (int s = 0; s < ST; s++)
        seq_notes[(c*ST+s)*NW +: NW] = notes[c][s];
  end

  sfx_sequencer #(.CHANNELS(CH), .STEPS(ST), .NOTE_W(NW), .STEP_CYCLES(SC), .AMP(16'h1000)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .stop(stop), .loop_en(loop_en),
    .pan_left(pan_left), .pan_right(pan_right), .seq_notes(seq_notes),
    .audio_left(al), .audio_right(ar), .busy(busy), .done(done));

  sfx_sequencer #(.CHANNELS(CH), .STEPS(ST), .NOTE_W(NW), .STEP_CYCLES(SC), .AMP(16'h7000)) dut_sat (
    .clk(clk), .rst(rst), .trigger(trigger), .stop(stop), .loop_en(loop_en),
    .pan_left(pan_left), .pan_right(pan_right), .seq_notes(seq_notes),
    .audio_left(sl), .audio_right(sr), .busy(sbusy), .done(sdone));

  // Reference model state: playback start cycle per channel, derived purely from elapsed time.
  bit m_play [CH];
  bit m_done [CH];
  bit m_prev [CH];
  int m_start [CH];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  function automatic int n_valid(int c);
    for (int s = 0; s < ST; s++) if (notes[c][s] == ENDN) return s;
    return ST;
  endfunction

  function automatic int lvl_sign(int c);
    int e, s, w, half;
    logic [NW-1:0] nt;
    if (!m_play[c]) return 0;
    e = cyc - m_start[c];
    s = e / SC;
    w = e % SC;
    if (s >= ST) return 0;
    nt = notes[c][s];
    if (nt < 2 || nt == ENDN) return 0;
    half = int'(nt >> 1);
    return ((w / half) % 2 == 0) ? 1 : -1;
  endfunction

  function automatic logic [15:0] sat16(int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_play[c] = 0; m_done[c] = 0; m_prev[c] = 0; m_start[c] = 0;
    end
  endtask

  // One clock: predict from current inputs, step the model, clock, then compare all outputs.
  task automatic tick();
    int sum_l, sum_r, sg;
    logic [15:0] e_al, e_ar, e_sl, e_sr;
    logic [CH-1:0] e_busy, e_done;
    sum_l = 0; sum_r = 0;
    for (int c = 0; c < CH; c++) begin
      sg = lvl_sign(c);
      if (pan_left[c])  sum_l += sg;
      if (pan_right[c]) sum_r += sg;
    end
    e_al = sat16(sum_l * 'h1000); e_ar = sat16(sum_r * 'h1000);
    e_sl = sat16(sum_l * 'h7000); e_sr = sat16(sum_r * 'h7000);
    for (int c = 0; c < CH; c++) begin
      m_done[c] = 0;
      if (stop[c]) m_play[c] = 0;
      else if (trigger[c] && !m_prev[c]) begin
        if (n_valid(c) == 0) begin m_play[c] = 0; m_done[c] = 1; end
        else begin m_play[c] = 1; m_start[c] = cyc + 1; end
      end else if (m_play[c] && (cyc - m_start[c] + 1 == n_valid(c) * SC)) begin
        m_done[c] = 1;
        if (loop_en[c]) m_start[c] = cyc + 1;
        else m_play[c] = 0;
      end
      m_prev[c] = trigger[c];
      e_busy[c] = m_play[c];
      e_done[c] = m_done[c];
    end
    @(posedge clk); #1;
    cyc++;
    vectors += 8;
    if (busy !== e_busy)  begin miscompares++; $display("FAIL busy @%0d: got %b want %b", cyc, busy, e_busy); end
    if (done !== e_done)  begin miscompares++; $display("FAIL done @%0d: got %b want %b", cyc, done, e_done); end
    if (sbusy !== e_busy) begin miscompares++; $display("FAIL sat busy @%0d: got %b want %b", cyc, sbusy, e_busy); end
    if (sdone !== e_done) begin miscompares++; $display("FAIL sat done @%0d: got %b want %b", cyc, sdone, e_done); end
    if (al !== e_al) begin miscompares++; $display("FAIL audio_left @%0d: got %h want %h", cyc, al, e_al); end
    if (ar !== e_ar) begin miscompares++; $display("FAIL audio_right @%0d: got %h want %h", cyc, ar, e_ar); end
    if (sl !== e_sl) begin miscompares++; $display("FAIL sat audio_left @%0d: got %h want %h", cyc, sl, e_sl); end
    if (sr !== e_sr) begin miscompares++; $display("FAIL sat audio_right @%0d: got %h want %h", cyc, sr, e_sr); end
  endtask

  task automatic quiesce();
    stop = '1; trigger = '0; loop_en = '0;
    tick();
    stop = '0;
    tick();
  endtask

  task automatic set_notes(int c, int n0, int n1, int n2, int n3);
    notes[c][0] = NW'(n0); notes[c][1] = NW'(n1); notes[c][2] = NW'(n2); notes[c][3] = NW'(n3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trigger = '0; stop = '0; loop_en = '0; pan_left = '0; pan_right = '0;
    for (int c = 0; c < CH; c++) set_notes(c, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({al, ar, busy, done} !== '0) begin
      miscompares++; $display("FAIL reset state: got %h", {al, ar, busy, done});
    end
    rst = 1'b0;
    set_notes(0, 8, 8, 8, 8);
    pan_left = 2'b01; pan_right = 2'b01;
    trigger = 2'b01;
    tick();
    repeat (10) tick();
    trigger = '0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({al, ar, busy, done} !== '0) begin
      miscompares++; $display("FAIL reset mid-play: got %h want 0", {al, ar, busy, done});
    end
    model_reset();
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_basic();
    int t0, done_cyc, fall_cyc;
    quiesce();
    set_notes(0, 8, 0, 4, int'(ENDN));
    pan_left = 2'b01; pan_right = 2'b00;
    done_cyc = -1; fall_cyc = -1;
    t0 = cyc;
    trigger = 2'b01;
    tick();
    while (cyc < t0 + 60) begin
      if (done[0] && done_cyc < 0) done_cyc = cyc;
      if (!busy[0] && fall_cyc < 0) fall_cyc = cyc;
      tick();
    end
    vectors += 2;
    if (done_cyc != t0 + 49) begin miscompares++; $display("FAIL basic done cycle: got %0d want %0d", done_cyc - t0, 49); end
    if (fall_cyc != t0 + 49) begin miscompares++; $display("FAIL basic busy fall: got %0d want %0d", fall_cyc - t0, 49); end
    trigger = '0;
    tick();
  endtask

  task automatic test_saturation();
    int t0;
    quiesce();
    set_notes(0, 8, 8, 8, 8);
    set_notes(1, 8, 8, 8, 8);
    pan_left = 2'b11; pan_right = 2'b00;
    t0 = cyc;
    trigger = 2'b11;
    tick();
    while (cyc < t0 + 70) begin
      if (cyc == t0 + 2 || cyc == t0 + 6) begin
        vectors++;
        if (sl !== ((cyc == t0 + 2) ? 16'h7FFF : 16'h8000)) begin
          miscompares++; $display("FAIL saturation @t+%0d: got %h", cyc - t0, sl);
        end
      end
      tick();
    end
    trigger = '0;
    tick();
  endtask

  task automatic test_retrigger();
    int t1, done_cyc;
    quiesce();
    set_notes(0, 6, 10, 4, 2);
    pan_left = 2'b01; pan_right = 2'b01;
    done_cyc = -1;
    trigger = 2'b01;
    tick();
    repeat (39) tick();
    trigger = '0;
    tick();
    t1 = cyc;
    trigger = 2'b01;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (done[0] && done_cyc < 0) done_cyc = cyc;
    end
    vectors++;
    if (done_cyc != t1 + 1 + 4 * SC) begin
      miscompares++; $display("FAIL retrigger completion: got %0d want %0d", done_cyc - t1, 1 + 4 * SC);
    end
    trigger = '0;
    tick();
  endtask

  task automatic test_loop_stop();
    int t0, n_done, n_idle;
    quiesce();
    set_notes(0, int'($urandom_range(2, 20)), int'($urandom_range(2, 20)),
                 int'($urandom_range(2, 20)), int'($urandom_range(2, 20)));
    pan_left = 2'b01; pan_right = 2'b01;
    loop_en = 2'b01;
    n_done = 0; n_idle = 0;
    t0 = cyc;
    trigger = 2'b01;
    tick();
    while (cyc < t0 + 200) begin
      if (done[0]) n_done++;
      if (!busy[0]) n_idle++;
      tick();
    end
    vectors += 2;
    if (n_done != 3) begin miscompares++; $display("FAIL loop done count: got %0d want 3", n_done); end
    if (n_idle != 0) begin miscompares++; $display("FAIL loop busy drop: got %0d idle cycles want 0", n_idle); end
    trigger = '0;
    tick();
    stop = 2'b01; trigger = 2'b01;
    tick();
    vectors++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      miscompares++; $display("FAIL stop+trigger: got busy %b done %b want 0 0", busy[0], done[0]);
    end
    stop = '0; loop_en = '0;
    repeat (3) tick();
    trigger = '0;
    tick();
  endtask

  task automatic test_end0();
    quiesce();
    set_notes(0, int'(ENDN), 8, 8, 8);
    pan_left = 2'b01; pan_right = 2'b01;
    trigger = 2'b01;
    tick();
    vectors++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL end0 pulse: got done %b busy %b want 1 0", done[0], busy[0]);
    end
    repeat (6) tick();
    trigger = '0;
    tick();
  endtask

  task automatic test_random();
    int r;
    quiesce();
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (!m_play[c] && $urandom_range(0, 30) == 0)
          for (int s = 0; s < ST; s++) begin
            r = int'($urandom_range(0, 9));
            notes[c][s] = (r == 0) ? NW'(0) : (r == 1) ? NW'(1) : (r == 2) ? ENDN
                        : NW'($urandom_range(2, 24));
          end
        if ($urandom_range(0, 7) == 0) trigger[c] = ~trigger[c];
        stop[c] = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 50) == 0) loop_en[c] = ~loop_en[c];
        if ($urandom_range(0, 20) == 0) pan_left[c] = ~pan_left[c];
        if ($urandom_range(0, 20) == 0) pan_right[c] = ~pan_right[c];
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_retrigger();
    test_loop_stop();
    test_end0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
